// File: rtl/mc_main_controller.sv
// mc_main_controller: multicycle RV32I control FSM driving datapath selects, strobes and ALU select.
// Optional ILLEGAL_TRAP_EN: unknown opcodes enter an absorbing TRAP state flagged on `illegal`.
module mc_main_controller #(
   parameter int MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic [2:0] alu_control,
`ifdef ILLEGAL_TRAP_EN
   output logic       illegal,
`endif
   output logic       instr_done
);
   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);
   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, OR = 3'b011,
                          XOR = 3'b100, SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_TRAP
   } state_t;
   state_t r_state, w_state;
   logic [CW-1:0] r_cnt, w_cnt;
   logic w_last, w_pc_update, w_branch, w_mem_write, w_ir_write, w_reg_write, w_done;
   logic [2:0] w_falu;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
      end
   always_comb begin
      w_last      = r_cnt == LAST;
      w_state     = r_state;
      w_cnt       = '0;
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_write = 1'b0;
      w_done      = 1'b0;
      adr_src     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = ADD;
      case (funct3)
         3'b000:  w_falu = (r_state == S_EXECR && funct7b5) ? SUB : ADD;
         3'b001:  w_falu = SLL;
         3'b010,
         3'b011:  w_falu = SLT;
         3'b100:  w_falu = XOR;
         3'b101:  w_falu = SRL;
         3'b110:  w_falu = OR;
         default: w_falu = AND;
      endcase
      case (r_state)
         S_FETCH: begin
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            w_cnt       = w_last ? '0 : r_cnt + 1'b1;
            w_ir_write  = w_last;
            w_pc_update = w_last;
            w_state     = w_last ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               7'b0000011,
               7'b0100011: w_state = S_MEMADR;
               7'b0110011: w_state = S_EXECR;
               7'b0010011: w_state = S_EXECI;
               7'b1101111: w_state = S_JAL;
               7'b1100011: w_state = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
               default:    w_state = S_TRAP;
`else
               default:    w_state = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            w_state   = op == 7'b0000011 ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            w_cnt   = w_last ? '0 : r_cnt + 1'b1;
            w_state = w_last ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            w_reg_write = 1'b1;
            w_done      = 1'b1;
            w_state     = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            w_mem_write = 1'b1;
            w_done      = 1'b1;
            w_state     = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = w_falu;
            w_state     = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = w_falu;
            w_state     = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
            w_done      = 1'b1;
            w_state     = S_FETCH;
         end
         S_JAL: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            w_pc_update = 1'b1;
            w_state     = S_ALUWB;
         end
         S_BRANCH: begin
            alu_src_a   = 2'b10;
            alu_control = SUB;
            w_branch    = 1'b1;
            w_done      = 1'b1;
            w_state     = S_FETCH;
         end
         S_TRAP:  w_state = S_TRAP;
         default: w_state = S_FETCH;
      endcase
   end
   // Strobes are gated by rst_n so nothing fires while reset is held, even though FETCH is current.
   assign pc_write   = rst_n & (w_pc_update | (w_branch & (zero ^ funct3[0])));
   assign ir_write   = rst_n & w_ir_write;
   assign mem_write  = rst_n & w_mem_write;
   assign reg_write  = rst_n & w_reg_write;
   assign instr_done = rst_n & w_done;
   assign imm_src    = op == 7'b0100011 ? 2'b01 : op == 7'b1100011 ? 2'b10 :
                       op == 7'b1101111 ? 2'b11 : 2'b00;
`ifdef ILLEGAL_TRAP_EN
   assign illegal = r_state == S_TRAP;
`endif
endmodule
